// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit, 3-bit-opcode ALU, its stimulus side and
// the response checker: opcodes, datapath width and checker state encoding.
package alu_pkg;

    localparam int unsigned ALU_W = 16;

    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b001;
    localparam logic [2:0] OP_SUB   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_SHL   = 3'b101;
    localparam logic [2:0] OP_SHR   = 3'b110;
    localparam logic [2:0] OP_PASSA = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_resp_checker_ref.sv
// Combinational golden model of the ALU: expected result of (a, b, op), mod 2^W.
// Shared by the checker and any bench that needs the same reference.
module alu_ref_model
    import alu_pkg::*;
#(
    parameter int unsigned W = ALU_W
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [2:0]   op_i,
    output logic [W-1:0] y_o
);

    always_comb begin
        y_o = a_i;
        case (op_i)
            OP_AND:   y_o = a_i & b_i;
            OP_ADD:   y_o = a_i + b_i;
            OP_SUB:   y_o = a_i - b_i;
            OP_OR:    y_o = a_i | b_i;
            OP_XOR:   y_o = a_i ^ b_i;
            OP_SHL:   y_o = {a_i[W-2:0], 1'b0};
            OP_SHR:   y_o = {1'b0, a_i[W-1:1]};
            default:  y_o = a_i;
        endcase
    end

endmodule

// File: rtl/alu_resp_checker.sv
// ALU response checker: recomputes each accepted result through a two-stage
// pipeline and counts transactions/mismatches. Optional ALU_CHK_RUNSUM_EN adds runsum.
module alu_resp_checker
    import alu_pkg::*;
#(
    parameter int unsigned NUM_TXN = 1000,
    parameter int unsigned W       = ALU_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic [2:0]   in_op,
    input  logic [W-1:0] in_result,
    output logic [15:0]  txn_count,
    output logic [15:0]  err_count,
    output logic [15:0]  first_err_idx,
    output logic         done,
    output logic         pass,
`ifdef ALU_CHK_RUNSUM_EN
    output logic [W-1:0] runsum,
`endif
    output state_t       dbg_state
);

    localparam int unsigned CNT_W = $clog2(NUM_TXN + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_TXN - 1);

    state_t           state_q;
    logic             ready_q;
    logic             done_q;
    logic [CNT_W-1:0] acc_q;
    logic [15:0]      txn_q;
    logic [15:0]      err_q;
    logic [15:0]      fidx_q;
    logic             have_err_q;

    logic             s1_vld_q;
    logic [W-1:0]     s1_exp_q;
    logic [W-1:0]     s1_res_q;
    logic [15:0]      s1_idx_q;

    logic [W-1:0]     exp_w;
    logic             xfer;
    logic             mismatch;
    logic [15:0]      txn_d;
    logic [15:0]      err_d;

`ifdef ALU_CHK_RUNSUM_EN
    logic [W-1:0]     runsum_q;
    logic [W-1:0]     runsum_d;
    assign runsum_d = runsum_q + in_result;
    assign runsum   = runsum_q;
`endif

    alu_ref_model #(.W(W)) u_ref (
        .a_i  (in_a),
        .b_i  (in_b),
        .op_i (in_op),
        .y_o  (exp_w)
    );

    assign xfer     = in_valid && ready_q;
    assign mismatch = s1_vld_q && (s1_exp_q != s1_res_q);
    assign txn_d    = (txn_q == 16'hFFFF) ? txn_q : txn_q + 16'd1;
    assign err_d    = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            acc_q      <= '0;
            txn_q      <= '0;
            err_q      <= '0;
            fidx_q     <= 16'hFFFF;
            have_err_q <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_exp_q   <= '0;
            s1_res_q   <= '0;
            s1_idx_q   <= '0;
`ifdef ALU_CHK_RUNSUM_EN
            runsum_q   <= '0;
`endif
        end else begin
            // Stage 1: capture the transfer with its index and expected value.
            s1_vld_q <= xfer;
            if (xfer) begin
                s1_exp_q <= exp_w;
                s1_res_q <= in_result;
                s1_idx_q <= txn_q;
            end

            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q    <= RUN;
                        ready_q    <= 1'b1;
                        done_q     <= 1'b0;
                        acc_q      <= '0;
                        txn_q      <= '0;
                        err_q      <= '0;
                        fidx_q     <= 16'hFFFF;
                        have_err_q <= 1'b0;
`ifdef ALU_CHK_RUNSUM_EN
                        runsum_q   <= '0;
`endif
                    end
                end
                RUN: begin
                    if (xfer) begin
                        acc_q <= acc_q + CNT_W'(1);
                        txn_q <= txn_d;
`ifdef ALU_CHK_RUNSUM_EN
                        runsum_q <= runsum_d;
`endif
                        if (acc_q == LAST_IDX) begin
                            ready_q <= 1'b0;
                        end
                    end
                    // Stage 2: compare and record the verdict.
                    if (mismatch) begin
                        err_q <= err_d;
                        if (!have_err_q) begin
                            fidx_q     <= s1_idx_q;
                            have_err_q <= 1'b1;
                        end
                    end
                    // Ready only drops on the final transfer, so this is that one draining.
                    if (!ready_q && s1_vld_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready      = ready_q;
    assign txn_count     = txn_q;
    assign err_count     = err_q;
    assign first_err_idx = fidx_q;
    assign done          = done_q;
    assign pass          = done_q && (err_q == 16'd0);
    assign dbg_state     = state_q;

endmodule

// File: doc/alu_resp_checker.md
# alu_resp_checker

Synthesizable response checker for the 16-bit, 3-bit-opcode ALU: accepts one (a, b, op, result) transaction per cycle from the ALU's output side, recomputes the expected result, and counts transactions and mismatches. It is the consuming end of the stimulus path that drives the ALU. The bench sweeps 1000 random operand pairs through the ALU, and this block turns the `$monitor`-style inspection into an on-chip pass/fail verdict.

## Interface
- `NUM_TXN`, 1000: transactions per run; run ends after this many accepted.
- `W`, 16: operand/result width.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; begins a run from IDLE or DONE.
- `in_valid` in 1: transaction present.
- `in_ready` out 1: checker accepts this cycle.
- `in_a` in W: operand A as driven into ALU.
- `in_b` in W: operand B.
- `in_op` in 3: ALU opcode.
- `in_result` in W: ALU `sum` output for that transaction.
- `txn_count` out 16: accepted transactions this run.
- `err_count` out 16: mismatches this run.
- `first_err_idx` out 16: index of first mismatch (0-based); 16'hFFFF if none.
- `done` out 1: high in DONE state.
- `pass` out 1: `done && err_count == 0`.
- `runsum` out W: running sum of accepted results (only with macro, see Configuration).

## Operation
- States: IDLE → (start) → RUN → (NUM_TXN accepted and pipeline drained) → DONE → (start) → RUN.
- `start` in RUN is ignored.
- Entering RUN clears:
  - all counters,
  - `runsum`,
  - `first_err_idx` (to 16'hFFFF).
- `in_ready` = 1 only in RUN while accepted < NUM_TXN. A transfer occurs when `in_valid && in_ready`.
- Expected result, all mod 2^W:
  - 000 A&B
  - 001 A+B
  - 010 A−B
  - 011 A|B
  - 100 A^B
  - 101 A<<1
  - 110 A>>1 (logical)
  - 111 A
- Mismatch: expected ≠ `in_result`, compared on all W bits.
- `txn_count` and `err_count` saturate at 16'hFFFF; neither wraps.
- `first_err_idx` latches the `txn_count` value of the first mismatching transfer and holds until the next run.

## Timing
- Reset values:
  - state IDLE
  - `in_ready` 0
  - `txn_count` 0
  - `err_count` 0
  - `first_err_idx` 16'hFFFF
  - `done` 0
  - `pass` 0
  - `runsum` 0
- Two-stage pipeline:
  - Stage 1 registers the inputs and the expected value.
  - Stage 2 compares, then updates `err_count` and `first_err_idx`.
- `txn_count` increments in the cycle after the transfer.
- `err_count` reflects a transfer 2 cycles after it.
- DONE is entered 2 cycles after the NUM_TXN-th transfer; `done` is asserted from that cycle.
- `in_ready` drops in the cycle after the NUM_TXN-th transfer. No back-pressure otherwise: the checker accepts one transfer per clock.
- Asynchronous reset mid-run aborts immediately. In-flight pipeline contents are discarded.
- `start` coincident with the last transfer is ignored (state is still RUN).

## Configuration
- `ALU_CHK_RUNSUM_EN` defined:
  - `runsum` port exists.
  - It accumulates `in_result` mod 2^W on every transfer and is updated in the cycle after the transfer.
- `ALU_CHK_RUNSUM_EN` undefined:
  - Port and accumulator are absent.
  - All other behaviour is identical.

## Structure
- Shared package `alu_pkg`:
  - opcode localparams (`OP_AND`…`OP_PASSA`),
  - width constant 16,
  - state enum {IDLE, RUN, DONE}.
- The ALU bench and `aluIn` reference the same package.
- Sub-module `alu_ref_model`: combinational expected-result function of (a, b, op). It is reusable by the bench.

## Test plan
- Reset with `rst_n`=0 → all outputs at reset values. `start` → `in_ready`=1 the following cycle.
- NUM_TXN=4; drive op 001 with (3,1,4), (9,1,10), (0,1,1), (65535,1,0) → `done`=1, `pass`=1, `txn_count`=4, `err_count`=0, `runsum`=15.
- NUM_TXN=4; third transfer has op 010, a=5, b=1, result 5 → `err_count`=1, `first_err_idx`=2, `pass`=0.
- NUM_TXN=1000; random a∈[0,9], b=1, op 001, correct results → `done` 2 cycles after the 1000th transfer, `txn_count`=1000, `pass`=1.
- Deassert `rst_n` after 3 transfers → state IDLE and counters 0 immediately. A new `start` gives a clean run.
- Run to DONE, pulse `start` → counters cleared, `first_err_idx`=16'hFFFF, `in_ready`=1 the next cycle.
